// File: rtl/seg_disp_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display controller.
// Segment patterns are active-low, bit 0 = a ... bit 6 = g.
package seg_disp_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Entry k is the pattern for hex value k (index 15 is written first).
    localparam logic [15:0][6:0] HEX7 = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // Bits needed to hold 0..n-1, never less than one so ports stay legal.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// Display-side bundle: BCD frame inputs from the datapath, seg/an pins out.
interface seg_scan_display_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    enable;
    logic [4*NUM_DIGITS-1:0] digits_bcd;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic                    lz_blank;
    logic [7:0]              seg;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output enable, digits_bcd, dp_in, blink_mask, lz_blank,
        input  seg, an, frame_done
    );

    modport slave (
        input  enable, digits_bcd, dp_in, blink_mask, lz_blank,
        output seg, an, frame_done
    );
endinterface

// File: rtl/seg_scan_display_tick_gen.sv
// Free-running modulo-DIV counter; tick is high during the last count of each period.
module tick_gen
    import seg_disp_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = clog2_min1(DIV);

    logic [W-1:0] r_cnt;
    logic         w_last;

    assign w_last = (r_cnt == W'(DIV - 1));
    assign tick   = w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_cnt <= '0;
        else if (w_last) r_cnt <= '0;
        else             r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/seg_scan_display.sv
// Self-timed N-digit multiplexed 7-segment driver with frame shadow,
// per-digit blink/dp, leading-zero blanking and global enable.
module seg_scan_display
    import seg_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_HZ     = 100000000,
    parameter int SCAN_HZ    = 500,
    parameter int BLINK_HZ   = 2
) (
    input  logic               clk,
    input  logic               rst,
    seg_scan_display_if.slave  bus
);
    localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
    localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int IW        = clog2_min1(NUM_DIGITS);

    logic                    w_scan_tick;
    logic                    w_blink_tick;
    logic [IW-1:0]           r_idx;
    logic                    r_blink_phase;
    logic                    r_frame_done;
    logic [7:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [4*NUM_DIGITS-1:0] r_sh_digits;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic [NUM_DIGITS-1:0]   r_sh_blink;
    logic                    r_sh_lz;

    logic [3:0]              w_digit   [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   w_lz_hide;
    logic                    w_blank;
    logic                    w_wrap;

    tick_gen #(.DIV(SCAN_DIV))  u_scan  (.clk(clk), .rst(rst), .tick(w_scan_tick));
    tick_gen #(.DIV(BLINK_DIV)) u_blink (.clk(clk), .rst(rst), .tick(w_blink_tick));

    // A digit is a leading zero when it and every more significant digit are 0.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign w_digit[gi] = r_sh_digits[4*gi +: 4];
        if (gi == 0) begin : g_lsd
            assign w_lz_hide[gi] = 1'b0;
        end else begin : g_upper
            assign w_lz_hide[gi] = r_sh_lz && (r_sh_digits[4*NUM_DIGITS-1:4*gi] == '0);
        end
    end

    assign w_wrap  = w_scan_tick && (r_idx == IW'(NUM_DIGITS - 1));
    assign w_blank = !bus.enable
                   || (r_sh_blink[r_idx] && r_blink_phase)
                   || w_lz_hide[r_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx         <= '0;
            r_blink_phase <= 1'b0;
            r_frame_done  <= 1'b0;
            r_sh_digits   <= '0;
            r_sh_dp       <= '0;
            r_sh_blink    <= '0;
            r_sh_lz       <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
            if (w_blink_tick) r_blink_phase <= !r_blink_phase;
            if (w_wrap) begin
                r_idx       <= '0;
                r_sh_digits <= bus.digits_bcd;
                r_sh_dp     <= bus.dp_in;
                r_sh_blink  <= bus.blink_mask;
                r_sh_lz     <= bus.lz_blank;
            end else if (w_scan_tick) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Pin register: drives the digit selected by the current idx, one cycle behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= SEG_OFF;
            r_an  <= '1;
        end else if (w_blank) begin
            r_seg <= SEG_OFF;
            r_an  <= '1;
        end else begin
            r_seg <= {~r_sh_dp[r_idx], HEX7[w_digit[r_idx]]};
            r_an  <= ~(NUM_DIGITS'(1) << r_idx);
        end
    end

    assign bus.seg        = r_seg;
    assign bus.an         = r_an;
    assign bus.frame_done = r_frame_done;
endmodule
